pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Parametrised program-counter and fetch-request controller for the instruction-fetch stage. It holds the PC and drives a level request to instruction memory with an ack handshake. It advances sequentially, and supports stall, branch redirect and exception flush. It also reports each completed fetch address to the decode stage.

Parameters:
ADDR_W, 32, PC / address width in bits
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, low address bits that must be zero on any target
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (ADDR_W bits)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC; completed fetch is re-issued at the same address
br_valid_i  in  1  branch/jump redirect request
br_target_i  in  ADDR_W  branch target
flush_i  in  1  exception/flush redirect, highest priority
flush_target_i  in  ADDR_W  handler address
if_ack_i  in  1  memory completes current request this cycle
if_req_o  out  1  fetch request (ce)
if_addr_o  out  ADDR_W  current PC / fetch address
done_o  out  1  one-cycle pulse: a fetch completed last cycle
done_pc_o  out  ADDR_W  address of that completed fetch
misalign_o  out  1  one-cycle pulse: last accepted target had nonzero low bits

Behaviour:
- Reset (rst=1 at an edge): if_addr_o=RESET_VECTOR, if_req_o=0, done_o=0, done_pc_o=0, misalign_o=0, pending branch cleared, state=BOOT. Reset wins over every other input, including mid-request.
- States: BOOT, FETCH.
- BOOT: if_req_o=0. On the first edge with rst=0, go to FETCH and set if_req_o=1. The first request therefore appears exactly one cycle after reset deasserts, at RESET_VECTOR.
- FETCH: if_req_o=1 continuously. if_addr_o changes only at an edge where if_ack_i=1 or flush_i=1.
- Next-PC priority at each edge in FETCH:
  - 1 flush_i: PC=flush_target_i, applied even without ack. The in-flight request is abandoned and the pending branch is cleared.
  - 2 if_ack_i and (br_valid_i or pending): PC=br_target_i if br_valid_i this cycle, else the pending target. Pending is cleared.
  - 3 if_ack_i and stall_i: PC unchanged.
  - 4 if_ack_i: PC=PC+STEP, truncated to ADDR_W, so all-ones minus STEP+1 wraps to 0.
  - 5 no ack: PC unchanged.
- Branch without ack: target is latched into the pending register. A later branch before ack overwrites it (newest wins).
- stall_i does not block a branch or flush; a redirect overrides stall.
- done_o/done_pc_o: at an edge with if_ack_i=1 and flush_i=0, done_o=1 next cycle and done_pc_o=PC at the ack. Otherwise done_o=0 and done_pc_o holds its value. A flush coincident with ack suppresses done.
- Alignment: any accepted target (flush, or branch when applied or latched) has its ALIGN_BITS low bits forced to 0. If those bits were nonzero, misalign_o=1 for one cycle, the cycle after acceptance. ALIGN_BITS=0 disables the check.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/boot: rst=1 for 3 cycles then 0, if_ack_i=1 always -> if_req_o=0 during reset and the first cycle after; then if_addr_o=0,4,8,C on successive cycles; done_pc_o trails by one cycle.
- Wait states: ack every 3rd cycle -> if_addr_o holds each value 3 cycles; done_o pulses once per ack with the correct address; stall_i=1 on an ack -> same address fetched twice.
- Branch during wait: at PC=0x10, no ack, br_valid_i=1 target 0x40, then br 0x80 before ack -> on next ack PC=0x80 (0x40 discarded); with ack in the same cycle as br 0x40 -> PC=0x40 next cycle.
- Flush priority: flush_i=1 target 0x180, with br_valid_i=1 and if_ack_i=1 the same cycle -> PC=0x180, done_o=0 next cycle, pending cleared; flush with no ack -> immediate redirect.
- Misalign and wrap: br target 0x43 -> PC=0x40, misalign_o pulses once; ADDR_W=8, PC=0xFC, ack -> PC=0x00.
- Reset mid-operation: rst=1 while a pending branch exists and if_req_o=1 -> next cycle if_req_o=0, PC=RESET_VECTOR; after release, fetch resumes at RESET_VECTOR with no stale branch.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus between the PC/fetch controller and its surroundings
// (pipeline control, branch unit, instruction memory, decode).
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              stall_i;
  logic              br_valid_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_target_i;
  logic              if_ack_i;
  logic              if_req_o;
  logic [ADDR_W-1:0] if_addr_o;
  logic              done_o;
  logic [ADDR_W-1:0] done_pc_o;
  logic              misalign_o;

  // Controller side.
  modport master (
    input  stall_i, br_valid_i, br_target_i, flush_i, flush_target_i, if_ack_i,
    output if_req_o, if_addr_o, done_o, done_pc_o, misalign_o
  );

  // Environment side: pipeline control, branch unit, memory and decode.
  modport slave (
    output stall_i, br_valid_i, br_target_i, flush_i, flush_target_i, if_ack_i,
    input  if_req_o, if_addr_o, done_o, done_pc_o, misalign_o
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and level-request fetch controller with stall, pending
// branch redirect, exception flush and completed-fetch reporting.
module pc_fetch_ctrl #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       ALIGN_BITS   = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_ctrl_if.master bus
);

  // state | meaning
  // BOOT  | out of reset, no request yet; leaves on the first edge with rst=0
  // FETCH | request held high; PC moves on ack or flush
  typedef enum logic {BOOT, FETCH} state_t;

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic              done_q;
  logic [ADDR_W-1:0] done_pc_q;
  logic              misalign_q;
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_t_q;

  logic [ADDR_W-1:0] br_aligned;
  logic [ADDR_W-1:0] fl_aligned;
  logic              br_mis;
  logic              fl_mis;
  logic              ack_done;

  assign br_aligned = bus.br_target_i & ~LOW_MASK;
  assign fl_aligned = bus.flush_target_i & ~LOW_MASK;
  assign br_mis     = |(bus.br_target_i & LOW_MASK);
  assign fl_mis     = |(bus.flush_target_i & LOW_MASK);
  assign ack_done   = bus.if_ack_i & ~bus.flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      done_pc_q  <= '0;
      misalign_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
    end else begin
      misalign_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          req_q  <= 1'b1;
          done_q <= ack_done;
          if (ack_done) done_pc_q <= pc_q;
          // Redirect priority: flush, then branch (live or pending), then stall, then step.
          if (bus.flush_i) begin
            pc_q       <= fl_aligned;
            pend_v_q   <= 1'b0;
            misalign_q <= fl_mis;
          end else if (bus.if_ack_i && (bus.br_valid_i || pend_v_q)) begin
            pc_q       <= bus.br_valid_i ? br_aligned : pend_t_q;
            pend_v_q   <= 1'b0;
            misalign_q <= bus.br_valid_i & br_mis;
          end else if (bus.if_ack_i && bus.stall_i) begin
            pc_q <= pc_q;
          end else if (bus.if_ack_i) begin
            pc_q <= pc_q + STEP_W;
          end else if (bus.br_valid_i) begin
            // Latched targets are stored aligned; newest branch overwrites.
            pend_t_q   <= br_aligned;
            pend_v_q   <= 1'b1;
            misalign_q <= br_mis;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign bus.if_req_o   = req_q;
  assign bus.if_addr_o  = pc_q;
  assign bus.done_o     = done_q;
  assign bus.done_pc_o  = done_pc_q;
  assign bus.misalign_o = misalign_q;

endmodule
